pipelined_prefix_adder: RTL and testbench

PIPELINED_PREFIX_ADDER -- requirements
Module: pipelined_prefix_adder

---
 rtl/pipelined_prefix_adder.sv | 151 +++++++++++++++
 tb/tb_pipelined_prefix_adder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_prefix_adder.sv
// Add/subtract with a Sklansky carry tree split across STAGES registers; results carry cout, ovf, zero.
// Latency STAGES cycles, one result per cycle; per-stage valid bits stall upstream only when a stage is full.
module pipelined_prefix_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int LEVELS = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] h;
    logic             c0;
  } node_t;

  // Register r (r < STAGES-1) sits after tree level ((r+1)*LEVELS)/STAGES; -1 means no register there.
  function automatic int reg_slot(input int m);
    int slot;
    slot = -1;
    for (int r = 0; r < STAGES - 1; r++) begin
      if (((r + 1) * LEVELS) / STAGES == m) slot = r;
    end
    return slot;
  endfunction

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] vin;
  logic [STAGES-1:0] en;
  logic [STAGES:0]   rdy;

  always_comb begin
    rdy          = '0;
    vin          = '0;
    en           = '0;
    rdy[STAGES]  = out_ready;
    vin[0]       = in_valid;
    for (int r = 1; r < STAGES; r++) begin
      vin[r] = vld[r-1];
    end
    for (int r = STAGES - 1; r >= 0; r--) begin
      rdy[r] = !vld[r] || rdy[r+1];
      en[r]  = rdy[r] && vin[r];
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
    end else begin
      for (int r = 0; r < STAGES; r++) begin
        if (rdy[r]) vld[r] <= vin[r];
      end
    end
  end

  for (genvar m = 0; m <= LEVELS; m++) begin : g_lvl
    localparam int SLOT = reg_slot(m);
    node_t comb_n;
    node_t src_n;

    if (m == 0) begin : g_pre
      logic [WIDTH-1:0] bb;
      logic             c0;
      assign bb = op ? ~b : b;
      assign c0 = op ? ~cin : cin;
      // Carry-in is folded into bit 0's generate so every final G is a true carry out.
      always_comb begin
        comb_n.h    = a ^ bb;
        comb_n.p    = a ^ bb;
        comb_n.g    = a & bb;
        comb_n.g[0] = (a[0] & bb[0]) | ((a[0] ^ bb[0]) & c0);
        comb_n.c0   = c0;
      end
    end else begin : g_tree
      localparam int J = m - 1;
      node_t prv;
      assign prv = g_lvl[m-1].src_n;
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i >> J) & 1) == 1) begin : g_op
          localparam int K = ((i >> J) << J) - 1;
          assign comb_n.g[i] = prv.g[i] | (prv.p[i] & prv.g[K]);
          assign comb_n.p[i] = prv.p[i] & prv.p[K];
        end else begin : g_pass
          assign comb_n.g[i] = prv.g[i];
          assign comb_n.p[i] = prv.p[i];
        end
      end
      assign comb_n.h  = prv.h;
      assign comb_n.c0 = prv.c0;
    end

    if (SLOT >= 0) begin : g_reg
      node_t q;
      always_ff @(posedge clk) begin
        if (en[SLOT]) q <= comb_n;
      end
      assign src_n = q;
    end else begin : g_thru
      assign src_n = comb_n;
    end
  end

  node_t            fin;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic             zero_d;
  logic             unused_p;

  assign fin      = g_lvl[LEVELS].src_n;
  assign sum_d    = fin.h ^ {fin.g[WIDTH-2:0], fin.c0};
  assign cout_d   = fin.g[WIDTH-1];
  assign ovf_d    = fin.g[WIDTH-1] ^ fin.g[WIDTH-2];
  assign zero_d   = (sum_d == '0);
  // Group propagates are dead once every carry is resolved.
  assign unused_p = &fin.p;

  always_ff @(posedge clk) begin
    if (reset) begin
      s    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (en[STAGES-1]) begin
      s    <= sum_d;
      cout <= cout_d;
      ovf  <= ovf_d;
      zero <= zero_d;
    end
  end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Directed bench for the 16-bit/2-stage adder plus a randomised 64-bit/7-stage run against an arithmetic model.
module tb_pipelined_prefix_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, in_ready, cin, op, out_valid, out_ready, cout, ovf, zero;
  logic [15:0] a, b, s;

  pipelined_prefix_adder #(.WIDTH(16), .STAGES(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero)
  );

  logic        r_reset, r_in_valid, r_in_ready, r_cin, r_op, r_out_valid, r_out_ready;
  logic        r_cout, r_ovf, r_zero;
  logic [63:0] r_a, r_b, r_s;

  pipelined_prefix_adder #(.WIDTH(64), .STAGES(7)) dut64 (
    .clk(clk), .reset(r_reset), .in_valid(r_in_valid), .in_ready(r_in_ready),
    .a(r_a), .b(r_b), .cin(r_cin), .op(r_op),
    .out_valid(r_out_valid), .out_ready(r_out_ready),
    .s(r_s), .cout(r_cout), .ovf(r_ovf), .zero(r_zero)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        op;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  typedef struct packed {
    logic [63:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } r_t;

  vec_t       vt [16];
  logic [3:0] exp_q [$];
  r_t         rq [$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         n_out = 0;
  logic       st_acc, st_ov;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle on the 16-bit DUT: drive at negedge, sample 1 time unit later, score the handshake.
  task automatic step(input logic iv, input logic [3:0] vi, input logic ordy, input logic rst);
    logic [3:0] e;
    @(negedge clk);
    reset     = rst;
    in_valid  = iv;
    a         = vt[vi].a;
    b         = vt[vi].b;
    cin       = vt[vi].cin;
    op        = vt[vi].op;
    out_ready = ordy;
    #1;
    st_acc = iv && in_ready && !rst;
    st_ov  = out_valid;
    if (!rst && out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 64'(out_valid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("s[v%0d]", e), 64'(s), 64'(vt[e].s));
        chk($sformatf("cout[v%0d]", e), 64'(cout), 64'(vt[e].cout));
        chk($sformatf("ovf[v%0d]", e), 64'(ovf), 64'(vt[e].ovf));
        chk($sformatf("zero[v%0d]", e), 64'(zero), 64'(vt[e].zero));
        n_out++;
      end
    end
    if (st_acc) exp_q.push_back(vi);
    if (rst) exp_q.delete();
  endtask

  function automatic r_t ref64(input logic [63:0] x, input logic [63:0] y, input logic ci, input logic o);
    r_t          r;
    logic [63:0] yy;
    logic        c;
    logic [64:0] full;
    logic [63:0] low;
    yy     = o ? ~y : y;
    c      = o ? ~ci : ci;
    full   = {1'b0, x} + {1'b0, yy} + 65'(c);
    low    = {1'b0, x[62:0]} + {1'b0, yy[62:0]} + 64'(c);
    r.s    = full[63:0];
    r.cout = full[64];
    r.ovf  = low[63] ^ full[64];
    r.zero = (full[63:0] == 64'd0);
    return r;
  endfunction

  task automatic r_score();
    r_t e;
    if (r_out_valid && r_out_ready) begin
      if (rq.size() == 0) begin
        chk("r64_spurious", 64'(r_out_valid), 64'(0));
      end else begin
        e = rq.pop_front();
        chk("r64_s", r_s, e.s);
        chk("r64_flags", 64'({r_cout, r_ovf, r_zero}), 64'({e.cout, e.ovf, e.zero}));
      end
    end
    if (r_in_valid && r_in_ready) rq.push_back(ref64(r_a, r_b, r_cin, r_op));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   start;
    int   next;
    logic ordy;
    //            a         b       cin   op    s         cout  ovf   zero
    vt[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vt[4]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{16'h0010, 16'h0010, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[6]  = '{16'h0010, 16'h000F, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[7]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vt[9]  = '{16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[10] = '{16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    vt[11] = '{16'h8000, 16'h7FFF, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0};
    for (int i = 12; i < 16; i++) vt[i] = '0;

    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = 1'b0; out_ready = 1'b1;
    r_reset = 1'b1; r_in_valid = 1'b0; r_a = '0; r_b = '0; r_cin = 1'b0; r_op = 1'b0; r_out_ready = 1'b1;

    step(1'b0, 4'd0, 1'b1, 1'b1);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    r_reset = 1'b0;
    step(1'b0, 4'd0, 1'b1, 1'b0);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_s", 64'(s), 64'(0));
    chk("rst_flags", 64'({cout, ovf, zero}), 64'(0));
    chk("r64_rst_out_valid", 64'(r_out_valid), 64'(0));
    chk("r64_rst_in_ready", 64'(r_in_ready), 64'(1));

    // Single transactions: result must appear exactly two cycles after acceptance.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'(i), 1'b1, 1'b0);
      chk("lat_accept", 64'(st_acc), 64'(1));
      step(1'b0, 4'd0, 1'b1, 1'b0);
      chk("lat_cycle1_valid", 64'(out_valid), 64'(0));
      step(1'b0, 4'd0, 1'b1, 1'b0);
      chk("lat_cycle2_valid", 64'(out_valid), 64'(1));
    end

    // Back-to-back stream at full rate.
    for (int i = 4; i < 12; i++) begin
      step(1'b1, 4'(i), 1'b1, 1'b0);
      chk("tput_accept", 64'(st_acc), 64'(1));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b1, 1'b0);
    chk("tput_drained", 64'(exp_q.size()), 64'(0));

    // Ten sets with the consumer stalled in cycles 3-5.
    start = n_out;
    next  = 0;
    for (int c = 0; c < 40 && (n_out - start) < 10; c++) begin
      ordy = !(c inside {3, 4, 5});
      step(next < 10, (next < 10) ? 4'(next) : 4'd0, ordy, 1'b0);
      if (st_acc) next++;
      if (c >= 3 && c <= 5) begin
        chk("stall_in_ready", 64'(in_ready), 64'(0));
        chk("stall_s_held", 64'(s), 64'(vt[1].s));
      end
      if (c == 6) chk("resume_in_ready", 64'(in_ready), 64'(1));
    end
    chk("stream_delivered", 64'(n_out - start), 64'(10));
    chk("stream_accepted", 64'(next), 64'(10));
    chk("stream_q_empty", 64'(exp_q.size()), 64'(0));

    // Reset with two results in flight.
    step(1'b1, 4'd10, 1'b0, 1'b0);
    chk("flight_acc0", 64'(st_acc), 64'(1));
    step(1'b1, 4'd11, 1'b0, 1'b0);
    chk("flight_acc1", 64'(st_acc), 64'(1));
    step(1'b1, 4'd5, 1'b0, 1'b1);
    chk("flight_out_valid", 64'(st_ov), 64'(1));
    step(1'b0, 4'd0, 1'b1, 1'b0);
    chk("post_rst_out_valid", 64'(out_valid), 64'(0));
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'd0, 1'b1, 1'b0);
      chk("post_rst_no_stale", 64'(out_valid), 64'(0));
    end
    step(1'b1, 4'd4, 1'b1, 1'b0);
    chk("post_rst_accept", 64'(st_acc), 64'(1));
    step(1'b0, 4'd0, 1'b1, 1'b0);
    chk("post_rst_lat1", 64'(out_valid), 64'(0));
    step(1'b0, 4'd0, 1'b1, 1'b0);
    chk("post_rst_lat2", 64'(out_valid), 64'(1));

    // An offer during reset must be dropped even though in_ready is high.
    step(1'b1, 4'd6, 1'b1, 1'b1);
    chk("rst_offer_in_ready", 64'(in_ready), 64'(1));
    step(1'b0, 4'd0, 1'b1, 1'b0);
    chk("rst2_s", 64'(s), 64'(0));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'd0, 1'b1, 1'b0);
      chk("rst_offer_dropped", 64'(out_valid), 64'(0));
    end

    // Randomised 64-bit, 7-stage run with random valid/ready.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      r_in_valid  = ($urandom_range(0, 3) != 0);
      r_out_ready = ($urandom_range(0, 3) != 0);
      r_a         = {$urandom, $urandom};
      r_b         = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: r_a = '1;
        1: r_b = '1;
        2: r_b = r_a;
        3: r_a = 64'h7FFF_FFFF_FFFF_FFFF;
        default: ;
      endcase
      r_cin = 1'($urandom_range(0, 1));
      r_op  = 1'($urandom_range(0, 1));
      #1;
      r_score();
    end
    for (int c = 0; c < 60 && rq.size() > 0; c++) begin
      @(negedge clk);
      r_in_valid  = 1'b0;
      r_out_ready = 1'b1;
      #1;
      r_score();
    end
    chk("r64_drained", 64'(rq.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
